// File: rtl/sweep_ctrl_if.sv
// Bundles the sweep controller's request, bound, feedback and status signals.
// The master side is whoever owns start/stop/bounds and the counter's count;
// the slave side is sweep_ctrl itself.
interface sweep_ctrl_if #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 4
);
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [DWELL_W-1:0] dwell;
    logic [SWEEP_W-1:0] n_sweeps;
    logic [WIDTH-1:0]   count;
    logic               en;
    logic               dir;
    logic               busy;
    logic               done;
    logic               err;
    logic [SWEEP_W-1:0] sweep_cnt;

    modport master (
        output start, stop, lo, hi, dwell, n_sweeps, count,
        input  en, dir, busy, done, err, sweep_cnt
    );

    modport slave (
        input  start, stop, lo, hi, dwell, n_sweeps, count,
        output en, dir, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | waiting for start; rejects start when lo >= hi
//   SEEK       | walking the counter to lo (direction held in seek_dn_q)
//   UP         | climbing lo -> hi
//   DWELL_HI   | holding at hi for dwell+1 cycles
//   DOWN       | descending hi -> lo; completes one sweep
//   DWELL_LO   | holding at lo for dwell+1 cycles; decides repeat or finish
//   DONE       | one-cycle completion pulse
//
// The counter moves on the same edge that samples en=1, so every exit
// compare looks one step ahead (lo-1, hi-1, lo+1) to land exactly on a bound.
module sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 4
) (
    input logic         clk,
    input logic         rst,
    sweep_ctrl_if.slave sif
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEEK, S_UP, S_DWELL_HI, S_DOWN, S_DWELL_LO, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               seek_dn_q, seek_dn_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [SWEEP_W-1:0] nsw_q, nsw_d;
    logic [DWELL_W-1:0] timer_q, timer_d;
    logic [SWEEP_W-1:0] sweep_q, sweep_d;
    logic               err_q, err_d;

    // State, latched configuration, dwell timer and sweep counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            seek_dn_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
            nsw_q     <= '0;
            timer_q   <= '0;
            sweep_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seek_dn_q <= seek_dn_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dwell_q   <= dwell_d;
            nsw_q     <= nsw_d;
            timer_q   <= timer_d;
            sweep_q   <= sweep_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; stop pre-empts every non-idle state.
    always_comb begin
        state_d   = state_q;
        seek_dn_d = seek_dn_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        dwell_d   = dwell_q;
        nsw_d     = nsw_q;
        timer_d   = timer_q;
        sweep_d   = sweep_q;
        err_d     = 1'b0;

        if (state_q == S_IDLE) begin
            if (sif.start && !sif.stop) begin
                if (sif.lo >= sif.hi) begin
                    err_d = 1'b1;
                end else begin
                    lo_d    = sif.lo;
                    hi_d    = sif.hi;
                    dwell_d = sif.dwell;
                    nsw_d   = sif.n_sweeps;
                    sweep_d = '0;
                    if (sif.count == sif.lo) begin
                        state_d = S_UP;
                    end else begin
                        state_d   = S_SEEK;
                        seek_dn_d = (sif.count > sif.lo);
                    end
                end
            end
        end else if (sif.stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_SEEK: begin
                    // Arriving at lo from above counts as the end of a descent.
                    if (!seek_dn_q && sif.count == lo_q - WIDTH'(1)) begin
                        state_d = S_UP;
                    end else if (seek_dn_q && sif.count == lo_q + WIDTH'(1)) begin
                        state_d = S_DWELL_LO;
                        timer_d = dwell_q;
                    end
                end
                S_UP: begin
                    if (sif.count == hi_q - WIDTH'(1)) begin
                        state_d = S_DWELL_HI;
                        timer_d = dwell_q;
                    end
                end
                S_DWELL_HI: begin
                    if (timer_q == '0) state_d = S_DOWN;
                    else               timer_d = timer_q - DWELL_W'(1);
                end
                S_DOWN: begin
                    if (sif.count == lo_q + WIDTH'(1)) begin
                        state_d = S_DWELL_LO;
                        timer_d = dwell_q;
                        sweep_d = sweep_q + SWEEP_W'(1);
                    end
                end
                S_DWELL_LO: begin
                    if (timer_q != '0)                         timer_d = timer_q - DWELL_W'(1);
                    else if (nsw_q != '0 && sweep_q == nsw_q)  state_d = S_DONE;
                    else                                       state_d = S_UP;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sif.en        = (state_q == S_SEEK) || (state_q == S_UP) || (state_q == S_DOWN);
    assign sif.dir       = (state_q == S_DOWN) || ((state_q == S_SEEK) && seek_dn_q);
    assign sif.busy      = (state_q != S_IDLE);
    assign sif.done      = (state_q == S_DONE);
    assign sif.err       = err_q;
    assign sif.sweep_cnt = sweep_q;

endmodule
